// File: rtl/bbox_tracker_if.sv
// Pixel-stream and box-result bundle between the skin-mask source and the bounding-box tracker.
// The master drives the pixel stream; the slave (the tracker) returns the box.
interface bbox_tracker_if;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       pixel_valid;
   logic       skin;
   logic       frame_end;
   logic [9:0] left;
   logic [9:0] right;
   logic [9:0] top;
   logic [9:0] bottom;
   logic       box_valid;
   logic       box_update;

   modport master (
      output pixel_x, pixel_y, pixel_valid, skin, frame_end,
      input  left, right, top, bottom, box_valid, box_update
   );

   modport slave (
      input  pixel_x, pixel_y, pixel_valid, skin, frame_end,
      output left, right, top, bottom, box_valid, box_update
   );
endinterface

// File: rtl/bbox_tracker.sv
// Tracks the bounding box of skin-classified pixels per frame and publishes a margin-clamped
// box once per frame_end, qualified by a minimum pixel count.
module bbox_tracker #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int MIN_PIXELS = 200,
   parameter int MARGIN     = 5
) (
   input  logic           clk,
   input  logic           rst,
   bbox_tracker_if.slave  bus
);
   localparam logic [18:0] CNT_MIN    = 19'(MIN_PIXELS);
   localparam logic [18:0] CNT_SAT    = 19'h7FFFF;
   localparam logic [9:0]  MARGIN_V   = 10'(MARGIN);
   localparam logic [9:0]  RIGHT_LIM  = 10'(H_ACTIVE - 1 - MARGIN);
   localparam logic [9:0]  BOTTOM_LIM = 10'(V_ACTIVE - 1 - MARGIN);

   typedef enum logic {SYNC, ACCUM} state_t;

   state_t      state_reg, state_next;
   logic [9:0]  min_x_reg, min_x_next, max_x_reg, max_x_next;
   logic [9:0]  min_y_reg, min_y_next, max_y_reg, max_y_next;
   logic [18:0] cnt_reg, cnt_next;
   logic [9:0]  left_reg, left_next, right_reg, right_next;
   logic [9:0]  top_reg, top_next, bottom_reg, bottom_next;
   logic        box_valid_reg, box_valid_next;
   logic        box_update_reg, box_update_next;

   logic        counted;
   logic [9:0]  min_x_m, max_x_m, min_y_m, max_y_m;
   logic [18:0] cnt_m;
   logic [9:0]  left_c, right_c, top_c, bottom_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= SYNC;
         min_x_reg      <= 10'h3FF;
         min_y_reg      <= 10'h3FF;
         max_x_reg      <= 10'd0;
         max_y_reg      <= 10'd0;
         cnt_reg        <= 19'd0;
         left_reg       <= 10'd0;
         right_reg      <= 10'd0;
         top_reg        <= 10'd0;
         bottom_reg     <= 10'd0;
         box_valid_reg  <= 1'b0;
         box_update_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         min_x_reg      <= min_x_next;
         min_y_reg      <= min_y_next;
         max_x_reg      <= max_x_next;
         max_y_reg      <= max_y_next;
         cnt_reg        <= cnt_next;
         left_reg       <= left_next;
         right_reg      <= right_next;
         top_reg        <= top_next;
         bottom_reg     <= bottom_next;
         box_valid_reg  <= box_valid_next;
         box_update_reg <= box_update_next;
      end
   end

   // Accumulators merged with the current pixel, so a pixel arriving with frame_end
   // still belongs to the frame being closed.
   always_comb begin
      counted = (state_reg == ACCUM) && bus.pixel_valid && bus.skin &&
                (int'(bus.pixel_x) < H_ACTIVE) && (int'(bus.pixel_y) < V_ACTIVE);
      min_x_m = (counted && bus.pixel_x < min_x_reg) ? bus.pixel_x : min_x_reg;
      max_x_m = (counted && bus.pixel_x > max_x_reg) ? bus.pixel_x : max_x_reg;
      min_y_m = (counted && bus.pixel_y < min_y_reg) ? bus.pixel_y : min_y_reg;
      max_y_m = (counted && bus.pixel_y > max_y_reg) ? bus.pixel_y : max_y_reg;
      cnt_m   = (counted && cnt_reg != CNT_SAT) ? cnt_reg + 19'd1 : cnt_reg;

      left_c   = (min_x_m < MARGIN_V)   ? MARGIN_V   : min_x_m;
      top_c    = (min_y_m < MARGIN_V)   ? MARGIN_V   : min_y_m;
      right_c  = (max_x_m > RIGHT_LIM)  ? RIGHT_LIM  : max_x_m;
      bottom_c = (max_y_m > BOTTOM_LIM) ? BOTTOM_LIM : max_y_m;
   end

   always_comb begin
      state_next      = state_reg;
      min_x_next      = min_x_m;
      max_x_next      = max_x_m;
      min_y_next      = min_y_m;
      max_y_next      = max_y_m;
      cnt_next        = cnt_m;
      left_next       = left_reg;
      right_next      = right_reg;
      top_next        = top_reg;
      bottom_next     = bottom_reg;
      box_valid_next  = box_valid_reg;
      box_update_next = 1'b0;

      if (bus.frame_end) begin
         state_next      = ACCUM;
         min_x_next      = 10'h3FF;
         min_y_next      = 10'h3FF;
         max_x_next      = 10'd0;
         max_y_next      = 10'd0;
         cnt_next        = 19'd0;
         box_update_next = 1'b1;
         if (state_reg == ACCUM) begin
            if (cnt_m >= CNT_MIN) begin
               left_next      = left_c;
               right_next     = right_c;
               top_next       = top_c;
               bottom_next    = bottom_c;
               // Clamping can invert a box that hugs a border; edges still update.
               box_valid_next = (left_c <= right_c) && (top_c <= bottom_c);
            end else begin
               box_valid_next = 1'b0;
            end
         end
      end
   end

   assign bus.left       = left_reg;
   assign bus.right      = right_reg;
   assign bus.top        = top_reg;
   assign bus.bottom     = bottom_reg;
   assign bus.box_valid  = box_valid_reg;
   assign bus.box_update = box_update_reg;
endmodule

// File: tb/tb_bbox_tracker.sv
// Directed stimulus for bbox_tracker; expected boxes are queued at each frame_end and a
// monitor compares them against every box_update pulse.
module tb_bbox_tracker;
   typedef struct {
      logic [9:0] l, r, t, b;
      logic       v;
   } box_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   box_t exp_q[$];

   bbox_tracker_if bus ();

   bbox_tracker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: one pop per box_update cycle.
   always @(negedge clk) begin
      if (!rst && bus.box_update === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_update: got box_update=1, expected 0");
         end else begin
            box_t e;
            e = exp_q.pop_front();
            check("left",      bus.left,   e.l);
            check("right",     bus.right,  e.r);
            check("top",       bus.top,    e.t);
            check("bottom",    bus.bottom, e.b);
            check("box_valid", {9'd0, bus.box_valid}, {9'd0, e.v});
            $display("update: box=(%0d,%0d,%0d,%0d) valid=%0b expected=(%0d,%0d,%0d,%0d) valid=%0b",
                     bus.left, bus.right, bus.top, bus.bottom, bus.box_valid,
                     e.l, e.r, e.t, e.b, e.v);
         end
      end
   end

   task automatic put(input int x, input int y, input bit v, input bit s, input bit fe);
      bus.pixel_x     = 10'(x);
      bus.pixel_y     = 10'(y);
      bus.pixel_valid = v;
      bus.skin        = s;
      bus.frame_end   = fe;
      @(posedge clk);
      #1;
   endtask

   task automatic block(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            put(x, y, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic expect_box(input int l, input int r, input int t, input int b, input bit v);
      box_t e;
      e.l = 10'(l); e.r = 10'(r); e.t = 10'(t); e.b = 10'(b); e.v = v;
      exp_q.push_back(e);
   endtask

   task automatic frame(input int l, input int r, input int t, input int b, input bit v);
      expect_box(l, r, t, b, v);
      put(0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_reset_outputs();
      check("rst_left",       bus.left,   10'd0);
      check("rst_right",      bus.right,  10'd0);
      check("rst_top",        bus.top,    10'd0);
      check("rst_bottom",     bus.bottom, 10'd0);
      check("rst_box_valid",  {9'd0, bus.box_valid},  10'd0);
      check("rst_box_update", {9'd0, bus.box_update}, 10'd0);
   endtask

   initial begin
      bus.pixel_x = '0; bus.pixel_y = '0;
      bus.pixel_valid = 1'b0; bus.skin = 1'b0; bus.frame_end = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // First frame_end only arms the tracker.
      frame(0, 0, 0, 0, 1'b0);

      // 20x15 = 300 pixel block.
      block(100, 119, 50, 64);
      frame(100, 119, 50, 64, 1'b1);

      // 15x10 = 150 pixels: too few, edges hold.
      block(200, 214, 10, 19);
      frame(100, 119, 50, 64, 1'b0);

      // Extremes at the frame borders clamp to the margin.
      put(0, 2, 1'b1, 1'b1, 1'b0);
      put(639, 479, 1'b1, 1'b1, 1'b0);
      block(300, 319, 200, 209);
      frame(5, 634, 5, 474, 1'b1);

      // Out-of-range, not-valid and non-skin pixels are never counted.
      put(700, 10, 1'b1, 1'b1, 1'b0);
      put(50, 50, 1'b0, 1'b1, 1'b0);
      put(10, 480, 1'b1, 1'b1, 1'b0);
      put(60, 60, 1'b1, 1'b0, 1'b0);
      frame(5, 634, 5, 474, 1'b0);

      // Pixel in the frame_end cycle joins the closing frame; back-to-back frame_end is empty.
      block(100, 119, 50, 64);
      expect_box(100, 600, 50, 400, 1'b1);
      put(600, 400, 1'b1, 1'b1, 1'b1);
      frame(100, 600, 50, 400, 1'b0);

      // Exactly MIN_PIXELS qualifies.
      block(10, 29, 10, 19);
      frame(10, 29, 10, 19, 1'b1);

      // One short of MIN_PIXELS.
      block(10, 29, 10, 18);
      block(10, 28, 19, 19);
      frame(10, 29, 10, 19, 1'b0);

      // Box inside the left margin: left clamps past right, edges update, not valid.
      block(0, 1, 100, 199);
      frame(5, 1, 100, 199, 1'b0);

      // Reset mid-frame after 250 pixels discards the partial frame.
      block(300, 324, 300, 309);
      put(0, 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      frame(0, 0, 0, 0, 1'b0);
      block(100, 119, 50, 64);
      frame(100, 119, 50, 64, 1'b1);

      put(0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL missing_update: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
